pll_reset_sequencer: RTL and testbench

- Sequences PLL bring-up and downstream reset release for the 100 MHz clock tree.
- Runs on the free-running 10 MHz reference clock, because the PLL output may be absent.
- Drives the PLL reset, waits for lock with a timeout, qualifies lock stability, then releases the system reset.
- Re-runs the sequence on lock loss or on request; latches a fault after repeated lock failures.

---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/sync_ff.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared state encodings and default timing for the PLL reset sequencer.
// Defaults assume a 10 MHz reference clock.
package pll_seq_pkg;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 10000;
    localparam int DEF_STABLE_CYCLES  = 1000;
    localparam int DEF_MAX_RETRIES    = 3;
    localparam int DEF_SYNC_STAGES    = 2;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_LOST      = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; latency STAGES cycles.
// No handshake: the input is a level that is simply resampled every cycle.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and downstream reset sequencer on the reference clock; optional PLL_SEQ_LOSS_COUNT_EN adds a lock-loss counter.
// Lock rise to STABLE is SYNC_STAGES+1 cycles; all outputs registered, no backpressure.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    localparam int RC_W          = $clog2(MAX_RETRIES + 1)
) (
    input  logic            clock_in,
    input  logic            rst_in,
    input  logic            pll_locked_in,
    input  logic            restart_in,
    output logic            pll_rst_out,
    output logic            sys_rst_n_out,
    output logic            ready_out,
    output logic            fault_out,
    output logic [2:0]      state_out,
    output logic [RC_W-1:0] retry_count_out
`ifdef PLL_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0]      lock_loss_count_out
`endif
);

    localparam int TMR_W = max2(max2($clog2(PLL_RST_CYCLES), $clog2(LOCK_TIMEOUT)), 1);
    localparam int STB_W = max2($clog2(STABLE_CYCLES), 1);

    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_MAX = RC_W'(MAX_RETRIES);

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [STB_W-1:0]  stb_q, stb_d;
    logic [RC_W-1:0]   retry_q, retry_d;
    logic              pll_rst_q, sys_rst_n_q, ready_q, fault_q;
    logic              lock_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i  (clock_in),
        .rst_ni (rst_in),
        .d_i    (pll_locked_in),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == LOCK_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_RESET_PLL;
                        retry_d = retry_q + RC_W'(1);
                    end
                end
            end
            ST_STABLE: begin
                // A dropout here only restarts qualification; it costs no retry.
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_q == STB_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                if (restart_in) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                end else if (!lock_s) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                state_d = ST_RESET_PLL;
                retry_d = '0;
            end
            ST_FAULT: begin
                if (restart_in) begin
                    state_d = ST_RESET_PLL;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
                retry_d = '0;
            end
        endcase
    end

    // Both counters restart on any state change, so neither can wrap.
    always_comb begin
        timer_d = timer_q;
        stb_d   = stb_q;
        if (state_d != state_q) begin
            timer_d = '0;
            stb_d   = '0;
        end else if (state_q == ST_RESET_PLL || state_q == ST_WAIT_LOCK) begin
            timer_d = timer_q + TMR_W'(1);
        end else if (state_q == ST_STABLE) begin
            stb_d = stb_q + STB_W'(1);
        end
    end

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_RESET_PLL;
            timer_q     <= '0;
            stb_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            stb_q       <= stb_d;
            retry_q     <= retry_d;
            // Outputs decoded from the next state so they change on the transition edge.
            pll_rst_q   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
            sys_rst_n_q <= (state_d == ST_RUN);
            ready_q     <= (state_d == ST_RUN);
            fault_q     <= (state_d == ST_FAULT);
        end
    end

`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            loss_cnt_q <= '0;
        end else if ((state_q == ST_RUN) && !lock_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_count_out = loss_cnt_q;
`endif

    assign pll_rst_out     = pll_rst_q;
    assign sys_rst_n_out   = sys_rst_n_q;
    assign ready_out       = ready_q;
    assign fault_out       = fault_q;
    assign state_out       = state_q;
    assign retry_count_out = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed table-driven bench for pll_reset_sequencer with short timing parameters.
module tb_pll_reset_sequencer;

    logic       clock_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       pll_locked_in = 1'b0;
    logic       restart_in = 1'b0;
    logic       pll_rst_out, sys_rst_n_out, ready_out, fault_out;
    logic [2:0] state_out;
    logic [1:0] retry_count_out;
`ifdef PLL_SEQ_LOSS_COUNT_EN
    logic [7:0] lock_loss_count_out;
`endif

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2),
        .SYNC_STAGES    (2)
    ) dut (
        .clock_in        (clock_in),
        .rst_in          (rst_in),
        .pll_locked_in   (pll_locked_in),
        .restart_in      (restart_in),
        .pll_rst_out     (pll_rst_out),
        .sys_rst_n_out   (sys_rst_n_out),
        .ready_out       (ready_out),
        .fault_out       (fault_out),
        .state_out       (state_out),
        .retry_count_out (retry_count_out)
`ifdef PLL_SEQ_LOSS_COUNT_EN
        ,
        .lock_loss_count_out (lock_loss_count_out)
`endif
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        int         w;
        logic       lock;
        logic       rq;
        logic [2:0] st;
        logic       pll;
        logic       sysn;
        logic       rdy;
        logic       flt;
        logic [1:0] rc;
    } vec_t;

    vec_t vt[35];

    function automatic vec_t mk(input int w, input logic l, input logic r, input int st,
                                input logic p, input logic s, input logic rd, input logic f,
                                input int rc);
        vec_t v;
        v.w = w; v.lock = l; v.rq = r; v.st = 3'(st);
        v.pll = p; v.sysn = s; v.rdy = rd; v.flt = f; v.rc = 2'(rc);
        return v;
    endfunction

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got st=%0d pll=%b sysn=%b rdy=%b flt=%b rc=%0d want st=%0d pll=%b sysn=%b rdy=%b flt=%b rc=%0d",
                     name, got[8:6], got[5], got[4], got[3], got[2], got[1:0],
                     exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
    endtask

    function automatic logic [8:0] outs();
        return {state_out, pll_rst_out, sys_rst_n_out, ready_out, fault_out, retry_count_out};
    endfunction

    task automatic apply_reset();
        rst_in = 1'b0;
        pll_locked_in = 1'b0;
        restart_in = 1'b0;
        step();
        step();
        check("in_reset", outs(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
        rst_in = 1'b1;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pll_locked_in = vt[i].lock;
            restart_in = vt[i].rq;
            if (vt[i].w > 0) begin
                step();
                restart_in = 1'b0;
                for (int k = 1; k < vt[i].w; k++) step();
            end
            check($sformatf("vec%0d", i), outs(),
                  {vt[i].st, vt[i].pll, vt[i].sysn, vt[i].rdy, vt[i].flt, vt[i].rc});
        end
    endtask

    initial begin
        // Nominal bring-up, then lock loss in RUN.
        vt[0]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        vt[1]  = mk(3, 0, 0, 0, 1, 0, 0, 0, 0);
        vt[2]  = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[3]  = mk(6, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[4]  = mk(2, 1, 0, 1, 0, 0, 0, 0, 0);
        vt[5]  = mk(1, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[6]  = mk(7, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[7]  = mk(1, 1, 0, 3, 0, 1, 1, 0, 0);
        vt[8]  = mk(2, 0, 0, 3, 0, 1, 1, 0, 0);
        vt[9]  = mk(1, 0, 0, 4, 0, 0, 0, 0, 0);
        vt[10] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0);
        // No lock: three attempts then FAULT; restart from FAULT and bring up.
        vt[11] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
        vt[12] = mk(4, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[13] = mk(19, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[14] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
        vt[15] = mk(4, 0, 0, 1, 0, 0, 0, 0, 1);
        vt[16] = mk(20, 0, 0, 0, 1, 0, 0, 0, 2);
        vt[17] = mk(23, 0, 0, 1, 0, 0, 0, 0, 2);
        vt[18] = mk(1, 0, 0, 5, 1, 0, 0, 1, 2);
        vt[19] = mk(10, 0, 0, 5, 1, 0, 0, 1, 2);
        vt[20] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);
        vt[21] = mk(4, 1, 0, 1, 0, 0, 0, 0, 0);
        vt[22] = mk(1, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[23] = mk(8, 1, 0, 3, 0, 1, 1, 0, 0);
        // Restart ignored in WAIT_LOCK, glitch in STABLE, lock fall with restart in RUN.
        vt[24] = mk(5, 0, 0, 1, 0, 0, 0, 0, 0);
        vt[25] = mk(1, 0, 1, 1, 0, 0, 0, 0, 0);
        vt[26] = mk(3, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[27] = mk(5, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[28] = mk(1, 0, 0, 2, 0, 0, 0, 0, 0);
        vt[29] = mk(2, 1, 0, 1, 0, 0, 0, 0, 0);
        vt[30] = mk(1, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[31] = mk(7, 1, 0, 2, 0, 0, 0, 0, 0);
        vt[32] = mk(1, 1, 0, 3, 0, 1, 1, 0, 0);
        vt[33] = mk(2, 0, 0, 3, 0, 1, 1, 0, 0);
        vt[34] = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);

        apply_reset();
        run(0, 10);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        checks++;
        if (lock_loss_count_out !== 8'd1) begin
            errors++;
            $display("FAIL loss_count_a got %0d want 1", lock_loss_count_out);
        end
`endif

        apply_reset();
        run(11, 23);
        // Asynchronous reset while in RUN, sampled well before the next edge.
        #2;
        rst_in = 1'b0;
        #1;
        check("async_rst_in_run", outs(), {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0});

        apply_reset();
        run(24, 34);
`ifdef PLL_SEQ_LOSS_COUNT_EN
        checks++;
        if (lock_loss_count_out !== 8'd1) begin
            errors++;
            $display("FAIL loss_count_c got %0d want 1", lock_loss_count_out);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
